// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester and its bus interface.
package apb_pkg;

  localparam int APB_ADDWIDTH  = 8;
  localparam int APB_DATAWIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_if.sv
// APB4 bus between one requester and one completer.
interface apb_if
  import apb_pkg::*;
#(
  parameter int ADDWIDTH  = APB_ADDWIDTH,
  parameter int DATAWIDTH = APB_DATAWIDTH
);

  logic                   PSEL;
  logic                   PENABLE;
  logic                   PWRITE;
  logic [ADDWIDTH-1:0]    PADDR;
  logic [DATAWIDTH-1:0]   PWDATA;
  logic [DATAWIDTH/8-1:0] PSTRB;
  logic                   PREADY;
  logic [DATAWIDTH-1:0]   PRDATA;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PRDATA
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PRDATA
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait counter; 'expired' flags the wait cycle whose count reaches TIMEOUT.
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = (TIMEOUT > 0) ? CW'(TIMEOUT) : '1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Abort decided on the same edge the count would reach TIMEOUT.
  assign expired = (TIMEOUT != 0) && en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB4 requester: valid/ready command in, SETUP/ACCESS transfer out,
// one-cycle response pulse carrying read data or a timeout error.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDWIDTH  = APB_ADDWIDTH,
  parameter int DATAWIDTH = APB_DATAWIDTH,
  parameter int TIMEOUT   = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDWIDTH-1:0]    cmd_addr,
  input  logic [DATAWIDTH-1:0]   cmd_wdata,
  input  logic [DATAWIDTH/8-1:0] cmd_strb,
  output logic                   rsp_valid,
  output logic [DATAWIDTH-1:0]   rsp_rdata,
  output logic                   rsp_err,
  apb_if.master                  apb
);

  apb_state_t state_q, state_d;
  logic       ready_q;
  logic       accept;
  logic       done;
  logic       wait_en;
  logic       expire;

  assign accept  = cmd_valid && cmd_ready;
  assign done    = (state_q == ACCESS) && apb.PREADY;
  assign wait_en = (state_q == ACCESS) && !apb.PREADY;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clr     (accept),
    .en      (wait_en),
    .expired (expire)
  );

  // ready_q keeps cmd_ready low until the first edge after reset release.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = ready_q;
        if (cmd_valid && ready_q) state_d = SETUP;
      end
      SETUP: begin
        apb.PSEL = 1'b1;
        state_d  = ACCESS;
      end
      ACCESS: begin
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b1;
        if (apb.PREADY || expire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command capture: pins stay put through SETUP/ACCESS and hold in IDLE.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      apb.PADDR  <= '0;
      apb.PWRITE <= 1'b0;
      apb.PWDATA <= '0;
      apb.PSTRB  <= '0;
    end else if (accept) begin
      apb.PADDR  <= cmd_addr;
      apb.PWRITE <= cmd_write;
      apb.PWDATA <= cmd_write ? cmd_wdata : '0;
      apb.PSTRB  <= cmd_write ? cmd_strb  : '0;
    end
  end

  // Response stage
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= done || expire;
      if (done) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= apb.PWRITE ? '0 : apb.PRDATA;
      end else if (expire) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master against a behavioural APB memory completer.
module tb_apb_master;
  import apb_pkg::*;

  logic PCLK = 1'b0;
  logic PRESETn;
  always #5 PCLK = ~PCLK;

  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  apb_if #(.ADDWIDTH(8), .DATAWIDTH(32)) apb ();

  apb_master #(.ADDWIDTH(8), .DATAWIDTH(32), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .apb(apb)
  );

  // Second requester with timeout disabled, facing a completer that never answers.
  logic        c0_valid, c0_ready, c0_write;
  logic [7:0]  c0_addr;
  logic [31:0] c0_wdata;
  logic [3:0]  c0_strb;
  logic        r0_valid, r0_err;
  logic [31:0] r0_rdata;

  apb_if #(.ADDWIDTH(8), .DATAWIDTH(32)) apb0 ();
  assign apb0.PREADY = 1'b0;
  assign apb0.PRDATA = 32'hFFFF_FFFF;

  apb_master #(.ADDWIDTH(8), .DATAWIDTH(32), .TIMEOUT(0)) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(c0_valid), .cmd_ready(c0_ready), .cmd_write(c0_write),
    .cmd_addr(c0_addr), .cmd_wdata(c0_wdata), .cmd_strb(c0_strb),
    .rsp_valid(r0_valid), .rsp_rdata(r0_rdata), .rsp_err(r0_err),
    .apb(apb0)
  );

  // Memory completer: PREADY in 5th ACCESS cycle. mode 1 = PREADY tied low,
  // mode 2 = PREADY lingers two cycles after completion.
  logic [31:0] mem [256];
  int          slave_mode = 0;
  logic        rdy_q;
  int          wcnt, stale_left;

  assign apb.PREADY = (slave_mode != 1) && (rdy_q || (stale_left > 0));
  assign apb.PRDATA = mem[apb.PADDR];

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rdy_q      <= 1'b0;
      wcnt       <= 0;
      stale_left <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (apb.PSEL && apb.PENABLE) begin
      if (apb.PREADY) begin
        if (apb.PWRITE)
          for (int b = 0; b < 4; b++)
            if (apb.PSTRB[b]) mem[apb.PADDR][8*b +: 8] <= apb.PWDATA[8*b +: 8];
        rdy_q      <= 1'b0;
        wcnt       <= 0;
        stale_left <= (slave_mode == 2) ? 2 : 0;
      end else begin
        if (wcnt == 3) rdy_q <= 1'b1;
        wcnt <= wcnt + 1;
      end
    end else begin
      rdy_q <= 1'b0;
      wcnt  <= 0;
      if (stale_left > 0) stale_left <= stale_left - 1;
    end
  end

  int rsp_cnt = 0, rsp0_cnt = 0;
  always @(posedge PCLK) begin
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (r0_valid)  rsp0_cnt <= rsp0_cnt + 1;
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    int          mode;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_psel;
    int          exp_pen;
  } vec_t;

  vec_t vecs[10];
  vec_t bq[3];
  int   bn;

  task automatic drive_cmd(input vec_t v);
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_strb  = v.strb;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int psel_n, pen_n, lat, waited, busy_rdy, pin_bad;
    logic got, er;
    logic [31:0] rd, exp_wd;
    logic [3:0]  exp_sb;
    string tag;
    tag    = $sformatf("vec%0d", id);
    exp_wd = v.wr ? v.wdata : 32'h0;
    exp_sb = v.wr ? v.strb : 4'h0;
    slave_mode = v.mode;
    @(negedge PCLK);
    drive_cmd(v);
    cmd_valid = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 20) begin @(negedge PCLK); waited++; end
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    if (!cmd_ready) begin cmd_valid = 1'b0; return; end
    psel_n = 0; pen_n = 0; lat = -1; busy_rdy = 0; pin_bad = 0;
    got = 1'b0; er = 1'b0; rd = 32'hx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge PCLK);
      if (k == 1) cmd_valid = 1'b0;
      if (apb.PSEL) psel_n++;
      if (apb.PENABLE) begin
        pen_n++;
        if (apb.PADDR !== v.addr || apb.PWRITE !== v.wr ||
            apb.PWDATA !== exp_wd || apb.PSTRB !== exp_sb) pin_bad++;
      end
      if (apb.PSEL && cmd_ready) busy_rdy++;
      if (rsp_valid) begin got = 1'b1; lat = k - 1; rd = rsp_rdata; er = rsp_err; break; end
    end
    check({tag, "_rsp_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, "_psel_cycles"}, 32'(psel_n), 32'(v.exp_psel));
    check({tag, "_penable_cycles"}, 32'(pen_n), 32'(v.exp_pen));
    check({tag, "_rdata"}, rd, v.exp_rdata);
    check({tag, "_err"}, 32'(er), 32'(v.exp_err));
    check({tag, "_pins_in_access"}, 32'(pin_bad), 32'd0);
    check({tag, "_ready_while_busy"}, 32'(busy_rdy), 32'd0);
    @(negedge PCLK);
    check({tag, "_rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
    check({tag, "_idle_psel"}, 32'(apb.PSEL), 32'd0);
    check({tag, "_paddr_held"}, 32'(apb.PADDR), 32'(v.addr));
  endtask

  task automatic run_burst(input string tag);
    int pres, nrsp, last, busy_rdy, miss_rdy, pen_n;
    logic will_acc;
    logic [31:0] rd[3];
    int sp[3];
    slave_mode = bq[0].mode;
    @(negedge PCLK);
    drive_cmd(bq[0]);
    cmd_valid = 1'b1;
    pres = 0; nrsp = 0; last = 0; busy_rdy = 0; miss_rdy = 0; pen_n = 0;
    for (int i = 0; i < 3; i++) begin rd[i] = 32'hx; sp[i] = -1; end
    for (int cyc = 1; cyc <= 80 && nrsp < bn; cyc++) begin
      will_acc = cmd_valid && cmd_ready;
      @(negedge PCLK);
      if (will_acc) begin
        pres++;
        if (pres < bn) drive_cmd(bq[pres]);
        else cmd_valid = 1'b0;
      end
      if (apb.PENABLE) pen_n++;
      if (apb.PSEL && cmd_ready) busy_rdy++;
      if (rsp_valid) begin
        rd[nrsp] = rsp_rdata;
        sp[nrsp] = cyc - last;
        last     = cyc;
        if (pres < bn && !cmd_ready) miss_rdy++;
        nrsp++;
      end
    end
    cmd_valid = 1'b0;
    check({tag, "_responses"}, 32'(nrsp), 32'(bn));
    check({tag, "_accepted"}, 32'(pres), 32'(bn));
    check({tag, "_ready_while_busy"}, 32'(busy_rdy), 32'd0);
    check({tag, "_ready_at_rsp"}, 32'(miss_rdy), 32'd0);
    check({tag, "_penable_cycles"}, 32'(pen_n), 32'(5 * bn));
    for (int i = 0; i < bn; i++) begin
      check($sformatf("%s_rdata%0d", tag, i), rd[i], bq[i].exp_rdata);
      check($sformatf("%s_spacing%0d", tag, i), 32'(sp[i]), 32'd7);
    end
    @(negedge PCLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited, rc0;
    vecs[0] = '{0, 1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF,    32'h0,         1'b0, 6,  6,  5};
    vecs[1] = '{0, 1'b1, 8'h10, 32'h1122_3344, 4'b0101, 32'h0,         1'b0, 6,  6,  5};
    vecs[2] = '{0, 1'b0, 8'h10, 32'h0,         4'h0,    32'hDE22_BE44, 1'b0, 6,  6,  5};
    vecs[3] = '{0, 1'b1, 8'hFF, 32'hA5A5_0F0F, 4'b1000, 32'h0,         1'b0, 6,  6,  5};
    vecs[4] = '{0, 1'b0, 8'hFF, 32'h0,         4'h0,    32'hA500_0000, 1'b0, 6,  6,  5};
    vecs[5] = '{0, 1'b1, 8'h20, 32'h1234_5678, 4'h0,    32'h0,         1'b0, 6,  6,  5};
    vecs[6] = '{0, 1'b0, 8'h20, 32'h0,         4'h0,    32'h0,         1'b0, 6,  6,  5};
    vecs[7] = '{1, 1'b0, 8'h10, 32'h0,         4'h0,    32'h0,         1'b1, 17, 17, 16};
    vecs[8] = '{1, 1'b1, 8'h10, 32'hFFFF_FFFF, 4'hF,    32'h0,         1'b1, 17, 17, 16};
    vecs[9] = '{0, 1'b0, 8'h10, 32'h0,         4'h0,    32'hDE22_BE44, 1'b0, 6,  6,  5};

    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    c0_valid = 1'b0; c0_write = 1'b0; c0_addr = 8'h05; c0_wdata = '0; c0_strb = '0;
    PRESETn = 1'b1;
    #2 PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    check("rst_psel", 32'(apb.PSEL), 32'd0);
    check("rst_penable", 32'(apb.PENABLE), 32'd0);
    check("rst_pwrite", 32'(apb.PWRITE), 32'd0);
    check("rst_paddr", 32'(apb.PADDR), 32'd0);
    check("rst_pwdata", apb.PWDATA, 32'd0);
    check("rst_pstrb", 32'(apb.PSTRB), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // Park the TIMEOUT=0 requester in ACCESS for the rest of the run.
    c0_valid = 1'b1;
    waited = 0;
    while (!c0_ready && waited < 20) begin @(negedge PCLK); waited++; end
    check("t0_accept", 32'(c0_ready), 32'd1);
    @(negedge PCLK);
    c0_valid = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    bn = 3;
    bq[0] = '{0, 1'b1, 8'h30, 32'h0000_0001, 4'hF, 32'h0,         1'b0, 6, 6, 5};
    bq[1] = '{0, 1'b1, 8'h31, 32'h0000_0002, 4'hF, 32'h0,         1'b0, 6, 6, 5};
    bq[2] = '{0, 1'b0, 8'h30, 32'h0,         4'h0, 32'h0000_0001, 1'b0, 6, 6, 5};
    run_burst("b2b");

    bn = 2;
    bq[0] = '{2, 1'b1, 8'h40, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0, 6, 6, 5};
    bq[1] = '{2, 1'b0, 8'h40, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0, 6, 6, 5};
    run_burst("stale");
    slave_mode = 0;
    repeat (3) @(negedge PCLK);

    check("t0_psel_held", 32'(apb0.PSEL), 32'd1);
    check("t0_penable_held", 32'(apb0.PENABLE), 32'd1);
    check("t0_no_rsp", 32'(rsp0_cnt), 32'd0);
    check("t0_not_ready", 32'(c0_ready), 32'd0);

    // Reset during the 3rd ACCESS cycle.
    @(negedge PCLK);
    cmd_write = 1'b0; cmd_addr = 8'h10; cmd_valid = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 20) begin @(negedge PCLK); waited++; end
    for (int k = 1; k <= 4; k++) begin
      @(negedge PCLK);
      if (k == 1) cmd_valid = 1'b0;
    end
    check("arst_in_access", 32'(apb.PSEL && apb.PENABLE), 32'd1);
    rc0 = rsp_cnt;
    #2 PRESETn = 1'b0;
    #1;
    check("arst_psel", 32'(apb.PSEL), 32'd0);
    check("arst_penable", 32'(apb.PENABLE), 32'd0);
    check("arst_paddr", 32'(apb.PADDR), 32'd0);
    check("arst_cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (2) @(negedge PCLK);
    check("arst_ready_held", 32'(cmd_ready), 32'd0);
    PRESETn = 1'b1;
    #1;
    check("arst_ready_before_edge", 32'(cmd_ready), 32'd0);
    @(negedge PCLK);
    check("arst_ready_after_edge", 32'(cmd_ready), 32'd1);
    check("arst_no_rsp", 32'(rsp_cnt - rc0), 32'd0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB4 requester that turns a valid/ready command port into APB SETUP/ACCESS transfers on one completer. It sits directly upstream of the team's APB memory slave (8-bit address, 32-bit data, byte strobes, multi-cycle PREADY) and drives its PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB pins. It returns read data, or a timeout error, as a one-cycle response pulse.

## Interface
- ADDWIDTH, 8, APB address width
- DATAWIDTH, 32, APB data width, multiple of 8
- TIMEOUT, 16, max ACCESS cycles without PREADY before abort; 0 disables timeout
- PCLK  in  1  single clock, all flops on rising edge
- PRESETn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at PCLK edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDWIDTH  target address
- cmd_wdata  in  DATAWIDTH  write data
- cmd_strb  in  DATAWIDTH/8  byte enables for writes
- rsp_valid  out  1  one-cycle pulse, transfer finished
- rsp_rdata  out  DATAWIDTH  read data; 0 for writes and errors
- rsp_err  out  1  timeout abort, qualified by rsp_valid
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDWIDTH  APB address
- PWDATA  out  DATAWIDTH  APB write data
- PSTRB  out  DATAWIDTH/8  APB strobes
- PREADY  in  1  completer ready
- PRDATA  in  DATAWIDTH  completer read data

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready = 1. It is 0 while PRESETn is low. On accept, latch the command onto the APB pins and go to SETUP.
- SETUP: PSEL = 1, PENABLE = 0, for exactly one cycle. Then go to ACCESS.
- ACCESS: PSEL = 1, PENABLE = 1. All address, control and data pins are held stable.
- ACCESS with PREADY = 1: at that edge, go to IDLE, pulse rsp_valid, and set rsp_err = 0.
  - For a read, rsp_rdata = PRDATA.
  - For a write, rsp_rdata = 0.
- ACCESS without PREADY: increment the wait counter. If TIMEOUT != 0 and the counter reaches TIMEOUT, go to IDLE and pulse rsp_valid with rsp_err = 1 and rsp_rdata = 0.
- Wait counter: width $clog2(TIMEOUT+1). It clears on entry to SETUP and saturates.
- PREADY and PRDATA are ignored outside ACCESS. The slave's PREADY can still be high for one cycle after completion; this must not complete the next transfer.
- Reads drive PSTRB = 0 and PWDATA = 0.
- In IDLE, PSEL = 0 and PENABLE = 0. PADDR, PWRITE, PWDATA and PSTRB hold their last values.
- cmd_valid while busy is not accepted. The source must hold the command.
- Asynchronous reset in any state:
  - All outputs go to 0 immediately, except cmd_ready, which is forced 0 while reset is held.
  - State returns to IDLE.
  - No response is issued for an aborted transfer.

## Timing
- Reset values: PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err all 0; cmd_ready 0 while in reset.
- Accept edge E0. SETUP occupies the cycle after E0. ACCESS begins after E1.
- With W wait cycles (PREADY low for W ACCESS cycles), the completion edge is E(2+W). rsp_valid is high for the single cycle after that edge.
- Against the memory slave: PREADY rises in the 5th ACCESS cycle (W = 4). That gives PSEL high 6 cycles, PENABLE high 5 cycles, and rsp_valid in the cycle after E6.
- rsp_valid coincides with IDLE, so a new command can be accepted in the same cycle. Minimum command-to-command spacing is 3+W edges.
- On timeout, PSEL and PENABLE drop after the TIMEOUT-th ACCESS cycle.

## Structure
- Shared package apb_pkg holds:
  - the state typedef apb_state_t (IDLE, SETUP, ACCESS);
  - default width constants APB_ADDWIDTH = 8 and APB_DATAWIDTH = 32.
- One natural sub-module: apb_wait_timer, a saturating counter with clear/enable and an expired flag parameterised by TIMEOUT. All other logic stays in apb_master.

## Test plan
- Write 32'hDEAD_BEEF, strb 4'hF, addr 8'h10, against the memory slave → PSEL high 6 cycles, PENABLE high 5, PSTRB = 4'hF, rsp_valid at E0+6 with rsp_err = 0 and rsp_rdata = 0.
- Write 32'h1122_3344, strb 4'b0101, addr 8'h10, then read addr 8'h10 → read returns rsp_rdata = 32'hDE22_BE44 and PSTRB = 0 during the read.
- Back-to-back: cmd_valid held high for 3 commands → each accepted in the rsp_valid cycle of the previous one. cmd_ready stays low from SETUP through ACCESS. No command is dropped.
- Stub completer with PREADY tied 0, TIMEOUT = 16 → PENABLE high exactly 16 cycles, then rsp_valid with rsp_err = 1 and rsp_rdata = 0. With TIMEOUT = 0 it stays in ACCESS indefinitely.
- PRESETn pulled low in the 3rd ACCESS cycle → PSEL and PENABLE go 0 without waiting for an edge. No rsp_valid. cmd_ready returns to 1 on the first edge after release.
- Stale PREADY: completer holds PREADY high one cycle past completion while the next command enters SETUP → that transfer still waits for a fresh PREADY in ACCESS.
